// File: rtl/branch_cmp_seq_pkg.sv
// Shared definitions for the sequential branch comparator.
//   br_op_e      : branch funct3 encodings (EQ/NE/LT/GE/LTU/GEU)
//   cmp_state_e  : controller states, mirrored as ST_* logic constants
//   is_signed()  : true for the signed compare opcodes (LT/GE)
//   br_result()  : maps funct3 plus the lt/eq flags onto the branch decision
// No ports; imported with import cmp_pkg::*.
// Optional feature macro used by the design: CMP_EARLY_EXIT_EN.

package cmp_pkg;

    typedef enum logic [2:0] {
        OP_EQ  = 3'b000,
        OP_NE  = 3'b001,
        OP_LT  = 3'b100,
        OP_GE  = 3'b101,
        OP_LTU = 3'b110,
        OP_GEU = 3'b111
    } br_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } cmp_state_e;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_BUSY = BUSY;
    localparam logic [1:0] ST_DONE = DONE;

    function automatic logic is_signed(input logic [2:0] op);
        return op[2:1] == 2'b10;
    endfunction

    // Illegal funct3 codes (010, 011) never take the branch.
    function automatic logic br_result(input logic [2:0] op, input logic lt, input logic eq);
        logic r;
        case (op)
            OP_EQ:          r = eq;
            OP_NE:          r = ~eq;
            OP_LT, OP_LTU:  r = lt;
            OP_GE, OP_GEU:  r = ~lt;
            default:        r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/branch_cmp_seq_if.sv
// Request/result handshake bundle for branch_cmp_seq.
//   in_valid_i / in_ready_o   : request handshake carrying a_i, b_i, op_i
//   out_valid_o / out_ready_i : result handshake carrying result_o, lt_o, eq_o
// master = requester (decode / PC-select side), slave = comparator.

interface branch_cmp_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [2:0]       op_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic             result_o;
    logic             lt_o;
    logic             eq_o;

    modport master (
        output in_valid_i, a_i, b_i, op_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, lt_o, eq_o
    );

    modport slave (
        input  in_valid_i, a_i, b_i, op_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, lt_o, eq_o
    );
endinterface

// File: rtl/branch_cmp_seq_cmp_chunk.sv
// cmp_chunk: combinational unsigned compare of one CHUNK-bit slice.
//   a, b : operand slices
//   lt   : a < b (unsigned)
//   eq   : a == b

module cmp_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             lt,
    output logic             eq
);
    assign lt = a < b;
    assign eq = a == b;
endmodule

// File: rtl/branch_cmp_seq.sv
// branch_cmp_seq: multi-cycle RISC-V branch comparator, CHUNK bits per cycle,
// most significant chunk first.
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   bus    : branch_cmp_seq_if.slave (request a/b/op, result result/lt/eq)
// Optional feature: define CMP_EARLY_EXIT_EN to finish on the first differing
// chunk instead of always walking all NCHUNK chunks.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | in_ready high, waiting for a request
// BUSY  | walking chunks NCHUNK-1 .. 0, latching the first decision
// DONE  | result registered, out_valid high until out_ready

module branch_cmp_seq
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    branch_cmp_seq_if.slave  bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("branch_cmp_seq: WIDTH must be a positive multiple of CHUNK");
    end

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic             lt_dec;
    logic             gt_dec;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             result_q;
    logic             lt_q;
    logic             eq_q;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic             chunk_lt;
    logic             chunk_eq;
    logic             undecided;
    logic             fin_lt;
    logic             fin_gt;
    logic             last;
    logic [WIDTH-1:0] sign_flip;

    // Flipping the sign bit of both operands turns a signed compare into an
    // unsigned one, so the chunk walker only ever does unsigned compares.
    always_comb begin
        sign_flip            = '0;
        sign_flip[WIDTH-1]   = is_signed(bus.op_i);
    end

    assign a_chunk = a_q[int'(cnt)*CHUNK +: CHUNK];
    assign b_chunk = b_q[int'(cnt)*CHUNK +: CHUNK];

    cmp_chunk #(.CHUNK(CHUNK)) u_cmp_chunk (
        .a  (a_chunk),
        .b  (b_chunk),
        .lt (chunk_lt),
        .eq (chunk_eq)
    );

    // Once a more significant chunk has decided, lower chunks are don't-care.
    assign undecided = ~lt_dec & ~gt_dec;
    assign fin_lt    = undecided ? chunk_lt              : lt_dec;
    assign fin_gt    = undecided ? (~chunk_lt & ~chunk_eq) : gt_dec;

`ifdef CMP_EARLY_EXIT_EN
    assign last = (cnt == '0) | (undecided & ~chunk_eq);
`else
    assign last = (cnt == '0);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            lt_dec      <= 1'b0;
            gt_dec      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= 1'b0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid_i && in_ready_q) begin
                        a_q        <= bus.a_i ^ sign_flip;
                        b_q        <= bus.b_i ^ sign_flip;
                        op_q       <= bus.op_i;
                        lt_dec     <= 1'b0;
                        gt_dec     <= 1'b0;
                        cnt        <= CW'(NCHUNK - 1);
                        in_ready_q <= 1'b0;
                        state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    lt_dec <= fin_lt;
                    gt_dec <= fin_gt;
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end
                    if (last) begin
                        lt_q        <= fin_lt;
                        eq_q        <= ~fin_lt & ~fin_gt;
                        result_q    <= br_result(op_q, fin_lt, ~fin_lt & ~fin_gt);
                        out_valid_q <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // in_ready only returns after this edge, so a request can
                    // never be taken on the DONE->IDLE edge itself.
                    if (bus.out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.result_o    = result_q;
    assign bus.lt_o        = lt_q;
    assign bus.eq_o        = eq_q;

endmodule
